// File: rtl/aes_arb_pkg.sv
// Shared types and default widths for the AES request arbiter.
package aes_arb_pkg;

  localparam int AES_DATA_W = 128;
  localparam int AES_KEY_L  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // (base + offs) mod modulus, for base < modulus and offs < modulus.
  function automatic int wrap_add(input int base, input int offs, input int modulus);
    return (base + offs >= modulus) ? base + offs - modulus : base + offs;
  endfunction

endpackage

// File: rtl/aes_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after rr_ptr,
// wrapping modulo N_REQ.
module aes_rr_picker
  import aes_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[PW'(wrap_add(int'(rr_ptr), i, N_REQ))]) begin
        any       = 1'b1;
        grant_idx = PW'(wrap_add(int'(rr_ptr), i, N_REQ));
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core among N_REQ requesters, one operation in flight.
// Optional WAIT watchdog compiled in with `define AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = AES_DATA_W,
  parameter int KEY_L   = AES_KEY_L,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*KEY_L-1:0]  req_key,
  input  logic [N_REQ*DATA_W-1:0] req_text,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    core_valid_in,
  output logic [KEY_L-1:0]        core_cipher_key,
  output logic [DATA_W-1:0]       core_plain_text,
  input  logic [DATA_W-1:0]       core_cipher_text,
  input  logic                    core_valid_out,
  output logic                    busy
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("aes_req_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_e        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx_q;
  logic [KEY_L-1:0]  key_q;
  logic [DATA_W-1:0] text_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              operands_live;

  logic [KEY_L-1:0]  key_slot  [N_REQ];
  logic [DATA_W-1:0] text_slot [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign key_slot[i]  = req_key[i*KEY_L +: KEY_L];
    assign text_slot[i] = req_text[i*DATA_W +: DATA_W];
  end

  aes_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // The grant is combinational in IDLE; reset_n masks it while reset is held.
  assign req_ready       = (reset_n && state == IDLE) ? pick_onehot : '0;
  assign operands_live   = (state == ISSUE) || (state == WAIT);
  assign core_valid_in   = (state == ISSUE);
  assign core_cipher_key = operands_live ? key_q  : '0;
  assign core_plain_text = operands_live ? text_q : '0;
  assign rsp_valid       = (state == RESP) ? (N_REQ'(1) << gnt_idx_q) : '0;
  assign rsp_data        = rsp_data_q;
  assign busy            = (state != IDLE);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog;
  logic              rsp_err_q;
  assign rsp_err = rsp_err_q && (state == RESP);
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: operand and result registers are plain flops (not a memory), so they
  // take the async reset and come out of reset as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx_q  <= '0;
      key_q      <= '0;
      text_q     <= '0;
      rsp_data_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      wdog       <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx_q <= pick_idx;
            key_q     <= key_slot[pick_idx];
            text_q    <= text_slot[pick_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef AES_ARB_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        WAIT: begin
          if (core_valid_out) begin
            rsp_data_q <= core_cipher_text;
            state      <= RESP;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
          end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
`endif
          end
        end
        RESP: begin
          // Only the owner's rsp_ready completes the handshake.
          if (rsp_ready[gnt_idx_q]) begin
            rr_ptr <= (gnt_idx_q == PW'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
